load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory-stage load/store unit between the RV32I execute stage and data_memory.
//  Loads: selects the byte, halfword or word and sign- or zero-extends it.
//  data_memory only writes whole 32-bit words, so SB/SH become a 2-cycle read-modify-write.
//  While a read-modify-write is in progress, the pipeline is stalled through req_ready.
// PARAMETERS
//  MEM_BYTES   32                  byte capacity of the attached data_memory (BLOCK_SIZE=8)
//  ADDR_WIDTH  $clog2(MEM_BYTES)   width of the byte address driven to memory
// PORTS
//  clk             in   1           core clock, all state on rising edge
//  rst_n           in   1           async active-low reset
//  req_valid       in   1           execute stage presents an access
//  req_ready       out  1           access accepted this cycle (valid&&ready)
//  req_we          in   1           1=store, 0=load
//  req_funct3      in   3           RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  req_addr        in   32          byte address from ALU
//  req_wdata       in   32          rs2 value for stores
//  rsp_valid       out  1           one-cycle pulse, one per accepted request
//  rsp_rdata       out  32          extended load data (0 for stores/errors)
//  rsp_err         out  1           qualifies rsp_valid: bad funct3 or out of range
//  mem_addr        out  ADDR_WIDTH  byte address to data_memory
//  mem_write_enable out 1           word write strobe to data_memory
//  mem_write_data  out  32          word written at mem_addr..mem_addr+3
//  mem_read_data   in   32          bytes mem_addr+3..mem_addr+0 (combinational)
// BEHAVIOUR
//  - FSM states: IDLE, RMW_WRITE. req_ready = (state==IDLE).
//  - Reset: state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0. Internal capture regs=0.
//    mem_write_enable=0 while rst_n is low; it is decoded from state and accept.
//  - IDLE, mem_addr = req_addr[ADDR_WIDTH-1:0].
//  - Range error: req_addr + size > MEM_BYTES, where size = 1/2/4.
//    Bad funct3: load funct3 in {3,6,7}; store funct3 > 2.
//    On error: no write, stay in IDLE, next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0.
//  - Load accept: next cycle rsp_valid=1 with registered rsp_rdata. Latency is 1.
//    LB/LH sign-extend bit 7/15 of mem_read_data; LBU/LHU zero-extend; LW passes through.
//  - SW accept: mem_write_enable=1 in the same cycle, with mem_write_data=req_wdata.
//    Next cycle: rsp_valid=1, rsp_err=0. State stays IDLE.
//  - SB/SH accept (read phase):
//    - Capture addr.
//    - Capture merged word = mem_read_data with [7:0] (SB) or [15:0] (SH) replaced by req_wdata.
//    - Go to RMW_WRITE.
//  - RMW_WRITE (write phase): mem_addr=captured addr, mem_write_enable=1, write the merged word.
//    Next state is IDLE, with rsp_valid=1 the following cycle. Store latency is 2 cycles.
//  - In RMW_WRITE, req_ready=0. The held request is not sampled until IDLE.
//  - Back-to-back: a new accept in IDLE may coincide with rsp_valid for the previous access.
//  - Async reset during RMW_WRITE: the write is aborted. Memory is untouched, no rsp_valid.
//  - Address wrap: none. Truncation to ADDR_WIDTH happens only after the range check passes.
// STRUCTURE
//  - rv32i_defs additions:
//    - funct3 enums load_funct3_t (LB=0, LH=1, LW=2, LBU=4, LHU=5).
//    - store_funct3_t (SB=0, SH=1, SW=2).
//    - Function access_size(funct3) returning 1/2/4.
//  - lsu_state_t {IDLE, RMW_WRITE} stays local to the module.
//  - One combinational sub-module lsu_data_align:
//    - Load extend: funct3, raw word -> rdata.
//    - Store merge: funct3, old word, wdata -> new word.
//  - FSM, capture registers and range check live in load_store_unit.
// TESTING (bench pairs with data_memory, MEM_BYTES=32)
//  1. SW addr 4, data 0xDEADBEEF; then LW 4 -> rsp_rdata=0xDEADBEEF, 1-cycle latency.
//  2. Then SB addr 5, data 0x12; then LW 4 -> req_ready low 1 cycle; rsp_rdata=0xDEAD12EF.
//  3. LB 4 -> 0xFFFFFFEF. LBU 4 -> 0x000000EF. LH 6 -> 0xFFFFDEAD. LHU 6 -> 0x0000DEAD.
//  4. SW addr 29 -> rsp_err=1, no write (LW 28 returns old value).
//     LB 31 is OK. Load funct3=3 -> rsp_err=1, rsp_rdata=0.
//  5. SH addr 8 with rst_n pulsed low during RMW_WRITE -> mem[8..11] stays 0, no rsp_valid.
//     Resume in IDLE.
//  6. SB then SB at the same address, issued back-to-back -> second write merges over the first.
//     Response count equals accept count.

Source files
------------

// File: rtl/rv32i_defs.sv
// rv32i_defs: shared RV32I load/store definitions.
//   load_funct3_t   funct3 encodings for LB/LH/LW/LBU/LHU
//   store_funct3_t  funct3 encodings for SB/SH/SW
//   access_size()   access width in bytes for a funct3
//   funct3_bad()    1 when funct3 is not a legal load/store encoding
package rv32i_defs;

   typedef enum logic [2:0] {
      LB  = 3'd0,
      LH  = 3'd1,
      LW  = 3'd2,
      LBU = 3'd4,
      LHU = 3'd5
   } load_funct3_t;

   typedef enum logic [2:0] {
      SB = 3'd0,
      SH = 3'd1,
      SW = 3'd2
   } store_funct3_t;

   // The low two funct3 bits encode the width for both loads and stores.
   function automatic logic [2:0] access_size(input logic [2:0] funct3);
      case (funct3[1:0])
         2'd0:    return 3'd1;
         2'd1:    return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic funct3_bad(input logic we, input logic [2:0] funct3);
      if (we) return funct3 > SW;
      return (funct3 == 3'd3) || (funct3 > LHU);
   endfunction

endpackage

// File: rtl/lsu_data_align.sv
// lsu_data_align: combinational data path of the load/store unit.
//   funct3      in   3   access type
//   mem_word    in   32  word read from data_memory at the access address
//   wdata       in   32  store data (rs2)
//   load_data   out  32  sign/zero-extended load result
//   store_word  out  32  mem_word with its low byte/halfword replaced (SB/SH),
//                        or wdata unchanged (SW)
// data_memory returns the addressed byte in bits [7:0], so no lane shifting.
module lsu_data_align
   import rv32i_defs::*;
(
   input  logic [2:0]  funct3,
   input  logic [31:0] mem_word,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_word
);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      load_data = mem_word;
      case (load_funct3_t'(funct3))
         LB:      load_data = {{24{mem_word[7]}}, mem_word[7:0]};
         LH:      load_data = {{16{mem_word[15]}}, mem_word[15:0]};
         LBU:     load_data = {24'd0, mem_word[7:0]};
         LHU:     load_data = {16'd0, mem_word[15:0]};
         default: load_data = mem_word;
      endcase
   end

   always_comb begin
      store_word = wdata;
      case (store_funct3_t'(funct3))
         SB:      store_word = {mem_word[31:8], wdata[7:0]};
         SH:      store_word = {mem_word[31:16], wdata[15:0]};
         default: store_word = wdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage LSU between RV32I execute and a word-write data_memory.
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake (ready low during RMW write phase)
//   req_we, req_funct3, req_addr,
//   req_wdata                       access description from execute
//   rsp_valid, rsp_rdata, rsp_err   one registered response per accepted request
//   mem_addr, mem_write_enable,
//   mem_write_data, mem_read_data   data_memory port (combinational read)
// SB/SH are read-modify-write: the merged word is captured on accept and
// written during the following RMW_WRITE cycle.
module load_store_unit
   import rv32i_defs::*;
#(
   parameter int MEM_BYTES  = 32,
   parameter int ADDR_WIDTH = $clog2(MEM_BYTES)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [31:0]           req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  rsp_valid,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_write_enable,
   output logic [31:0]           mem_write_data,
   input  logic [31:0]           mem_read_data
);

   typedef enum logic {IDLE, RMW_WRITE} lsu_state_t;

   lsu_state_t            state;
   logic [ADDR_WIDTH-1:0] cap_addr;
   logic [31:0]           cap_word;

   logic        accept;
   logic        req_err;
   logic        is_sw;
   logic        is_partial_store;
   logic [32:0] end_addr;
   logic [31:0] load_data;
   logic [31:0] store_word;

   lsu_data_align u_align (
      .funct3     (req_funct3),
      .mem_word   (mem_read_data),
      .wdata      (req_wdata),
      .load_data  (load_data),
      .store_word (store_word)
   );

   assign req_ready = (state == IDLE);
   assign accept    = req_valid && req_ready;

   // One extra bit so addresses near 2^32 cannot wrap past the range check.
   assign end_addr = {1'b0, req_addr} + {30'd0, access_size(req_funct3)};
   assign req_err  = funct3_bad(req_we, req_funct3) || (end_addr > 33'(MEM_BYTES));

   assign is_sw            = req_we && (req_funct3 == SW);
   assign is_partial_store = req_we && !req_err && !is_sw;

   assign mem_addr       = (state == RMW_WRITE) ? cap_addr : req_addr[ADDR_WIDTH-1:0];
   assign mem_write_data = (state == RMW_WRITE) ? cap_word : req_wdata;
   // Gated by rst_n so a reset landing mid-RMW (or during a held SW) never writes.
   assign mem_write_enable = rst_n &&
                             ((state == RMW_WRITE) || (accept && is_sw && !req_err));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         // NOTE: capture registers are reset too, so nothing stale leaks after an aborted RMW.
         cap_addr  <= '0;
         cap_word  <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register updating from pre-edge values.
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         case (state)
            IDLE: begin
               if (accept) begin
                  rsp_valid <= !is_partial_store;
                  rsp_err   <= req_err;
                  if (!req_we && !req_err) rsp_rdata <= load_data;
                  if (is_partial_store) begin
                     cap_addr <= req_addr[ADDR_WIDTH-1:0];
                     cap_word <= store_word;
                     state    <= RMW_WRITE;
                  end
               end
            end
            RMW_WRITE: begin
               rsp_valid <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed + randomized bench for load_store_unit with a
// byte-array data_memory model and a byte-level reference model.
module tb_load_store_unit;

   localparam int MEM_BYTES = 32;
   localparam int AW        = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [2:0]    req_funct3;
   logic [31:0]   req_addr;
   logic [31:0]   req_wdata;
   logic          rsp_valid;
   logic [31:0]   rsp_rdata;
   logic          rsp_err;
   logic [AW-1:0] mem_addr;
   logic          mem_write_enable;
   logic [31:0]   mem_write_data;
   logic [31:0]   mem_read_data;

   load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_we           (req_we),
      .req_funct3       (req_funct3),
      .req_addr         (req_addr),
      .req_wdata        (req_wdata),
      .rsp_valid        (rsp_valid),
      .rsp_rdata        (rsp_rdata),
      .rsp_err          (rsp_err),
      .mem_addr         (mem_addr),
      .mem_write_enable (mem_write_enable),
      .mem_write_data   (mem_write_data),
      .mem_read_data    (mem_read_data)
   );

   always #5 clk = ~clk;

   // data_memory model: combinational read of 4 bytes, word write on the clock edge.
   logic [7:0] mem [MEM_BYTES] = '{default: 8'h00};

   always_comb begin
      mem_read_data = '0;
      for (int i = 0; i < 4; i++)
         if (int'(mem_addr) + i < MEM_BYTES)
            mem_read_data[8*i +: 8] = mem[int'(mem_addr) + i];
   end

   always @(posedge clk)
      if (mem_write_enable)
         for (int i = 0; i < 4; i++)
            if (int'(mem_addr) + i < MEM_BYTES)
               mem[int'(mem_addr) + i] <= mem_write_data[8*i +: 8];

   // Reference model state.
   logic [7:0] ref_mem [MEM_BYTES] = '{default: 8'h00};

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          due;
      string       tag;
   } exp_t;

   exp_t        exp_q [$];
   int          tests   = 0;
   int          fails   = 0;
   int          cyc     = 0;
   int          acc_cnt = 0;
   int          rsp_cnt = 0;
   logic [31:0] last_rdata = '0;
   logic        last_err   = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Load result straight from the byte-level memory image and RV32I rules.
   function automatic logic [31:0] ref_load(input logic [2:0] f3, input int a);
      longint b [4];
      longint v;
      for (int i = 0; i < 4; i++) b[i] = (a + i < MEM_BYTES) ? longint'(ref_mem[a + i]) : 0;
      case (f3)
         3'd0:    begin v = b[0];              if (v > 127)   v = v - 256;   end
         3'd1:    begin v = b[0] + 256 * b[1]; if (v > 32767) v = v - 65536; end
         3'd4:    v = b[0];
         3'd5:    v = b[0] + 256 * b[1];
         default: v = b[0] + 256 * b[1] + 65536 * b[2] + 16777216 * b[3];
      endcase
      return v[31:0];
   endfunction

   // Response monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (rst_n && rsp_valid) begin
         rsp_cnt++;
         if (exp_q.size() == 0) begin
            check("unexpected_rsp", 32'(rsp_valid), 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.tag, "_err"}, 32'(rsp_err), 32'(e.err));
            check({e.tag, "_rdata"}, rsp_rdata, e.rdata);
            check({e.tag, "_latency"}, 32'(cyc), 32'(e.due));
            last_rdata = rsp_rdata;
            last_err   = rsp_err;
         end
      end
   end

   // Present one request, wait (bounded) for acceptance, record the expected response.
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input string tag, input bit aborted,
                        output int stalls);
      exp_t   e;
      int     size;
      logic   bad;
      logic   rng;
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      stalls     = 0;
      while (!req_ready && stalls < 8) begin
         @(negedge clk);
         stalls++;
      end
      if (!req_ready) begin
         check({tag, "_ready_timeout"}, 32'(req_ready), 32'd1);
         req_valid = 1'b0;
         return;
      end
      case (f3)
         3'd0, 3'd4: size = 1;
         3'd1, 3'd5: size = 2;
         default:    size = 4;
      endcase
      bad     = we ? (f3 > 3'd2) : ((f3 == 3'd3) || (f3 > 3'd5));
      rng     = (longint'(addr) + longint'(size)) > longint'(MEM_BYTES);
      e.tag   = tag;
      e.err   = bad || rng;
      e.due   = cyc + ((we && !e.err && f3 != 3'd2) ? 2 : 1);
      e.rdata = (!we && !e.err) ? ref_load(f3, int'(addr)) : 32'd0;
      if (!aborted) begin
         if (we && !e.err)
            for (int i = 0; i < size; i++) ref_mem[int'(addr) + i] = wd[8*i +: 8];
         exp_q.push_back(e);
         acc_cnt++;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 10) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   logic [2:0]  t_f3   [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
   int          t_addr [4] = '{4, 4, 6, 6};
   logic [31:0] t_exp  [4] = '{32'hFFFF_FFEF, 32'h0000_00EF, 32'hFFFF_DEAD, 32'h0000_DEAD};

   int          st;
   int          saved_rsp;
   logic        r_we;
   logic [2:0]  r_f3;
   logic [31:0] r_addr;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset with a legal SW held on the bus: nothing may be written.
      rst_n      = 1'b0;
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'd2;
      req_addr   = 32'd4;
      req_wdata  = 32'hCAFE_F00D;
      #3;
      check("reset_wen", 32'(mem_write_enable), 32'd0);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_rsp_rdata", rsp_rdata, 32'd0);
      check("reset_rsp_err", 32'(rsp_err), 32'd0);
      check("reset_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // SW then LW.
      issue(1'b1, 3'd2, 32'd4, 32'hDEAD_BEEF, "sw4", 1'b0, st);
      issue(1'b0, 3'd2, 32'd4, 32'd0, "lw4", 1'b0, st);
      drain();
      check("lw4_value", last_rdata, 32'hDEAD_BEEF);

      // SB stalls the following request by one cycle.
      issue(1'b1, 3'd0, 32'd5, 32'h0000_0012, "sb5", 1'b0, st);
      issue(1'b0, 3'd2, 32'd4, 32'd0, "lw4_merged", 1'b0, st);
      check("sb_stall_cycles", 32'(st), 32'd1);
      drain();
      check("lw4_merged_value", last_rdata, 32'hDEAD_12EF);

      // Byte/halfword extension.
      for (int i = 0; i < 4; i++) begin
         issue(1'b0, t_f3[i], 32'(t_addr[i]), 32'd0, "ext", 1'b0, st);
         drain();
         check($sformatf("ext%0d_value", i), last_rdata, t_exp[i]);
      end

      // Range and encoding errors.
      issue(1'b1, 3'd2, 32'd29, 32'h5555_5555, "sw29", 1'b0, st);
      drain();
      check("sw29_err", 32'(last_err), 32'd1);
      issue(1'b0, 3'd2, 32'd28, 32'd0, "lw28", 1'b0, st);
      drain();
      check("lw28_unchanged", last_rdata, 32'd0);
      issue(1'b0, 3'd0, 32'd31, 32'd0, "lb31", 1'b0, st);
      drain();
      check("lb31_ok", 32'(last_err), 32'd0);
      issue(1'b0, 3'd3, 32'd0, 32'd0, "ld_f3_3", 1'b0, st);
      drain();
      check("ld_f3_3_err", 32'(last_err), 32'd1);

      // Reset during the RMW write phase aborts the store.
      saved_rsp = rsp_cnt;
      issue(1'b1, 3'd1, 32'd8, 32'h0000_BEEF, "sh8_abort", 1'b1, st);
      rst_n = 1'b0;
      #1;
      check("abort_wen", 32'(mem_write_enable), 32'd0);
      check("abort_ready", 32'(req_ready), 32'd1);
      #1;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("abort_mem8", {mem[11], mem[10], mem[9], mem[8]}, 32'd0);
      check("abort_no_rsp", 32'(rsp_cnt), 32'(saved_rsp));
      issue(1'b0, 3'd2, 32'd8, 32'd0, "lw8_after_abort", 1'b0, st);
      drain();

      // Back-to-back SBs to the same byte.
      issue(1'b1, 3'd0, 32'd12, 32'h0000_0011, "sb12_a", 1'b0, st);
      issue(1'b1, 3'd0, 32'd12, 32'h0000_0022, "sb12_b", 1'b0, st);
      check("sb_b2b_stall", 32'(st), 32'd1);
      issue(1'b0, 3'd4, 32'd12, 32'd0, "lbu12", 1'b0, st);
      drain();
      check("lbu12_value", last_rdata, 32'h0000_0022);

      // Randomized traffic, including addresses near 2^32 that must not wrap.
      for (int i = 0; i < 80; i++) begin
         r_we   = 1'($urandom_range(0, 1));
         r_f3   = 3'($urandom_range(0, 7));
         r_addr = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                              : 32'($urandom_range(0, 35));
         issue(r_we, r_f3, r_addr, $urandom, "rnd", 1'b0, st);
      end
      drain();

      for (int w = 0; w < MEM_BYTES / 4; w++)
         check($sformatf("mem_word%0d", w),
               {mem[4*w+3], mem[4*w+2], mem[4*w+1], mem[4*w]},
               {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});
      check("rsp_count", 32'(rsp_cnt), 32'(acc_cnt));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
